uart_rx: RTL and testbench

- Asynchronous serial receiver for 8N1 frames: 1 start bit, 8 data bits LSB-first, no parity, 1 stop bit.
- Sits between an external RX pin and on-chip logic.
- Oversamples the line with the system clock, samples each bit at mid-bit, and presents the last good byte on a held register with a one-cycle done strobe.
- Default timing: 50 MHz clock, 19200 baud.

---
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver.
// The rx pin passes through a two-flop synchronizer. A falling edge on the
// synchronized line starts a frame. The start bit is confirmed at mid-bit.
// Each data bit is then sampled one full bit period later, LSB first.
// A good stop bit loads the held output register and pulses rx_done.
// A low stop bit pulses frame_err and leaves the held register untouched.
module uart_rx #(
    parameter  int CLK_FREQ     = 50000000,
    parameter  int BAUD         = 19200,
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD,
    localparam int HALF_BIT     = CLKS_PER_BIT / 2,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_reg,
    output logic       rx_done,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             rx_meta;
    logic             rx_s;
    logic             rx_prev;
    logic             rx_fall;

    // Resynchronize the pin and keep the previous value for edge detection;
    // all three flops reset high so a released reset does not look like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign rx_fall = rx_prev & ~rx_s;

    // Frame sequencer: mid-bit sampling, data shifting and registered strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cycle_cnt <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_reg    <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cycle_cnt <= '0;
                    bit_idx   <= '0;
                    if (rx_fall) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cycle_cnt == HALF_LAST) begin
                        cycle_cnt <= '0;
                        bit_idx   <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cycle_cnt == BIT_LAST) begin
                        cycle_cnt          <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cycle_cnt == BIT_LAST) begin
                        cycle_cnt <= '0;
                        state     <= IDLE;
                        if (rx_s) begin
                            rx_reg  <= shift_reg;
                            rx_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cycle_cnt <= '0;
                    bit_idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx, run with a shortened bit period (32 clocks).
// Frames are generated from plain byte/stop-bit descriptions.
// Outcomes are predicted from the framing rules alone:
// - a high stop bit delivers the byte;
// - a low stop bit raises one frame error;
// - the held byte only changes on a delivered frame.
module tb_uart_rx;

    localparam int CLK_FREQ = 3200000;
    localparam int BAUD     = 100000;
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int HALF     = BIT / 2;
    localparam int LAT_MIN  = 9 * BIT + HALF - 2;
    localparam int LAT_MAX  = 9 * BIT + HALF + 6;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_reg;
    logic       rx_done;
    logic       frame_err;

    int n_vec;
    int n_err;

    int   cyc;
    int   done_cnt;
    int   ferr_cnt;
    int   spurious_cnt;
    logic [7:0] prev_reg;
    logic [7:0] done_vals[$];
    int         done_cycs[$];

    logic [7:0] exp_reg;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_reg    (rx_reg),
        .rx_done   (rx_done),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            if (rx_done) begin
                done_cnt = done_cnt + 1;
                done_vals.push_back(rx_reg);
                done_cycs.push_back(cyc);
            end
            if (frame_err) ferr_cnt = ferr_cnt + 1;
            if (rx_reg !== prev_reg && !rx_done) spurious_cnt = spurious_cnt + 1;
        end
        prev_reg = rx_reg;
    end

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    // Drive one complete frame starting at a falling clock edge.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              output int start_cyc);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rx    = 1'b1;
        reset = 1'b0;
        #100;
        n_vec++;
        if (rx_reg !== 8'h00 || rx_done !== 1'b0 || frame_err !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_hold: rx_reg=%h done=%b ferr=%b, want 00/0/0",
                     rx_reg, rx_done, frame_err);
        end
        @(negedge clk);
        reset = 1'b1;
        idle_bits(1);
        n_vec++;
        if (rx_reg !== 8'h00 || done_cnt != 0 || ferr_cnt != 0) begin
            n_err++;
            $display("[TB] FAIL reset_idle: rx_reg=%h dones=%0d ferrs=%0d, want 00/0/0",
                     rx_reg, done_cnt, ferr_cnt);
        end
        exp_reg = 8'h00;
    endtask

    task automatic test_frame1;
        int d0;
        int f0;
        int sc;
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'hD1, 1'b1, sc);
        exp_reg = 8'hD1;
        idle_bits(1);
        n_vec++;
        if (done_cnt - d0 != 1 || ferr_cnt != f0) begin
            n_err++;
            $display("[TB] FAIL frame1_pulses: dones=%0d ferrs=%0d, want 1/0",
                     done_cnt - d0, ferr_cnt - f0);
        end
        n_vec++;
        if (rx_reg !== 8'hD1) begin
            n_err++;
            $display("[TB] FAIL frame1_data: rx_reg=%h, want d1", rx_reg);
        end
        n_vec++;
        if (done_cycs.size() == 0 ||
            done_cycs[$] - sc < LAT_MIN || done_cycs[$] - sc > LAT_MAX) begin
            n_err++;
            $display("[TB] FAIL frame1_latency: got %0d cycles, want %0d..%0d",
                     (done_cycs.size() == 0) ? -1 : done_cycs[$] - sc, LAT_MIN, LAT_MAX);
        end
    endtask

    task automatic test_reset_between;
        int d0;
        int sc;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (rx_reg !== 8'h00) begin
            n_err++;
            $display("[TB] FAIL reset_between: rx_reg=%h, want 00", rx_reg);
        end
        reset = 1'b1;
        exp_reg = 8'h00;
        idle_bits(1);
        d0 = done_cnt;
        send_frame(8'h2C, 1'b1, sc);
        exp_reg = 8'h2C;
        idle_bits(1);
        n_vec++;
        if (done_cnt - d0 != 1 || rx_reg !== 8'h2C) begin
            n_err++;
            $display("[TB] FAIL frame2: dones=%0d rx_reg=%h, want 1/2c",
                     done_cnt - d0, rx_reg);
        end
    endtask

    task automatic test_glitch;
        int d0;
        int f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        idle_bits(12);
        n_vec++;
        if (done_cnt != d0 || ferr_cnt != f0 || rx_reg !== exp_reg) begin
            n_err++;
            $display("[TB] FAIL glitch: dones=%0d ferrs=%0d rx_reg=%h, want 0/0/%h",
                     done_cnt - d0, ferr_cnt - f0, rx_reg, exp_reg);
        end
    endtask

    task automatic test_frame_error;
        int d0;
        int f0;
        int sc;
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b0, sc);
        idle_bits(1);
        n_vec++;
        if (ferr_cnt - f0 != 1 || done_cnt != d0) begin
            n_err++;
            $display("[TB] FAIL frame_err: ferrs=%0d dones=%0d, want 1/0",
                     ferr_cnt - f0, done_cnt - d0);
        end
        n_vec++;
        if (rx_reg !== exp_reg) begin
            n_err++;
            $display("[TB] FAIL frame_err_hold: rx_reg=%h, want %h", rx_reg, exp_reg);
        end
    endtask

    task automatic test_break;
        int d0;
        int f0;
        int sc;
        d0 = done_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (25 * BIT) @(negedge clk);
        rx = 1'b1;
        idle_bits(2);
        n_vec++;
        if (ferr_cnt - f0 != 1 || done_cnt != d0 || rx_reg !== exp_reg) begin
            n_err++;
            $display("[TB] FAIL break: ferrs=%0d dones=%0d rx_reg=%h, want 1/0/%h",
                     ferr_cnt - f0, done_cnt - d0, rx_reg, exp_reg);
        end
        d0 = done_cnt;
        send_frame(8'h3C, 1'b1, sc);
        exp_reg = 8'h3C;
        idle_bits(1);
        n_vec++;
        if (done_cnt - d0 != 1 || rx_reg !== 8'h3C) begin
            n_err++;
            $display("[TB] FAIL after_break: dones=%0d rx_reg=%h, want 1/3c",
                     done_cnt - d0, rx_reg);
        end
    endtask

    task automatic test_back_to_back;
        int q0;
        int sc;
        q0 = done_vals.size();
        send_frame(8'h55, 1'b1, sc);
        send_frame(8'hFF, 1'b1, sc);
        exp_reg = 8'hFF;
        idle_bits(1);
        n_vec++;
        if (done_vals.size() - q0 != 2) begin
            n_err++;
            $display("[TB] FAIL b2b_count: got %0d pulses, want 2", done_vals.size() - q0);
        end else begin
            n_vec++;
            if (done_vals[q0] !== 8'h55 || done_vals[q0+1] !== 8'hFF) begin
                n_err++;
                $display("[TB] FAIL b2b_data: got %h,%h want 55,ff",
                         done_vals[q0], done_vals[q0+1]);
            end
            n_vec++;
            if (done_cycs[q0+1] - done_cycs[q0] != 10 * BIT) begin
                n_err++;
                $display("[TB] FAIL b2b_spacing: got %0d cycles, want %0d",
                         done_cycs[q0+1] - done_cycs[q0], 10 * BIT);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int d0;
        logic [7:0] data;
        data = 8'h96;
        d0 = done_cnt;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = data[i];
            repeat (BIT) @(negedge clk);
        end
        rx = data[4];
        repeat (HALF) @(negedge clk);
        reset = 1'b0;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (rx_reg !== 8'h00) begin
            n_err++;
            $display("[TB] FAIL reset_mid: rx_reg=%h, want 00", rx_reg);
        end
        reset = 1'b1;
        exp_reg = 8'h00;
        idle_bits(12);
        n_vec++;
        if (done_cnt != d0 || rx_reg !== 8'h00) begin
            n_err++;
            $display("[TB] FAIL reset_mid_nodone: dones=%0d rx_reg=%h, want 0/00",
                     done_cnt - d0, rx_reg);
        end
    endtask

    task automatic test_random;
        logic [7:0] data;
        logic       stop_bit;
        int         d0;
        int         f0;
        int         sc;
        int         gap;
        for (int k = 0; k < 12; k++) begin
            data     = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            gap      = $urandom_range(0, 2);
            d0 = done_cnt;
            f0 = ferr_cnt;
            send_frame(data, stop_bit, sc);
            if (stop_bit) exp_reg = data;
            if (gap > 0) begin
                idle_bits(gap);
            end else begin
                repeat (2) @(negedge clk);
            end
            n_vec++;
            if (done_cnt - d0 != (stop_bit ? 1 : 0) ||
                ferr_cnt - f0 != (stop_bit ? 0 : 1) || rx_reg !== exp_reg) begin
                n_err++;
                $display("[TB] FAIL random_%0d: byte %h stop %b -> dones=%0d ferrs=%0d rx_reg=%h, want reg %h",
                         k, data, stop_bit, done_cnt - d0, ferr_cnt - f0, rx_reg, exp_reg);
            end
        end
        idle_bits(1);
    endtask

    task automatic test_hold;
        n_vec++;
        if (spurious_cnt != 0) begin
            n_err++;
            $display("[TB] FAIL reg_hold: rx_reg changed %0d times without rx_done, want 0",
                     spurious_cnt);
        end
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        cyc          = 0;
        done_cnt     = 0;
        ferr_cnt     = 0;
        spurious_cnt = 0;
        prev_reg     = 8'h00;
        exp_reg      = 8'h00;
        rx           = 1'b1;
        reset        = 1'b0;
        test_reset();
        test_frame1();
        test_reset_between();
        test_glitch();
        test_frame_error();
        test_break();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
